// File: rtl/cpu_pipe_pkg.sv
// Shared types and widths for the CPU pipeline stage registers.
package cpu_pipe_pkg;

    // Occupancy state of a pipeline stage register
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

    // Payload widths for each stage boundary
    localparam int unsigned IFID_W  = 64;   // instruction, pc
    localparam int unsigned IDEX_W  = 185;  // 5x32 + 5x5
    localparam int unsigned EXMEM_W = 69;   // aluResult, writeData, writeReg
    localparam int unsigned MEMWB_W = 69;   // readData, aluResult, writeReg

    // ID/EX payload as packed by the decode stage
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] readData1;
        logic [31:0] readData2;
        logic [31:0] signExt;
        logic [4:0]  readReg2;
        logic [4:0]  writeReg;
        logic [4:0]  Rs;
        logic [4:0]  Rt;
        logic [4:0]  Rd;
    } id_ex_t;

    // Number of held entries for a given state
    function automatic logic [1:0] occ_of(input pipe_state_t st);
        case (st)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module pipe_sat_counter
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear on clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid,
// stall/flush controls and a bubble counter for performance monitoring.
module pipe_stage_skid
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W        = 185,
    parameter bit          SKID_EN       = 1'b1,
    parameter bit          ZERO_ON_FLUSH = 1'b1,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         occupancy,
    output logic [COUNT_W-1:0] bubble_cnt,
    input  logic               clr_cnt
);

    pipe_state_t       state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              in_fire, out_fire;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_of(state);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready & ~stall & ~flush;

    // Upstream ready: registered-only path with skid, pass-through without
    always_comb begin
        in_ready = 1'b0;
        if (SKID_EN) begin
            in_ready = (state != FULL) & ~stall & ~flush & reset;
        end else begin
            in_ready = (~out_valid | out_ready) & ~stall & ~flush & reset;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and entry data; stall needs no branch since it masks both fires
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_nxt = '0;
                skid_nxt = '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire) begin
                        state_nxt = FULL;
                        skid_nxt  = in_data;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    if (ZERO_ON_FLUSH) begin : g_data_rst
        // Entry data registers, cleared by reset
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                main_q <= main_nxt;
                skid_q <= skid_nxt;
            end
        end
    end else begin : g_data_norst
        // Entry data registers; only the valid state is reset
        always_ff @(posedge clk) begin
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    pipe_sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~out_valid),
        .clr   (clr_cnt),
        .cnt   (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (skid and pass-through builds).
module tb_pipe_stage_skid;

    localparam int unsigned DW = 185;

    logic          clk;
    logic          reset;
    logic          stall, flush, clr_cnt;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [3:0]    bubble_cnt;

    logic          n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [DW-1:0] n_in_data, n_out_data;
    logic [1:0]    n_occupancy;
    logic [15:0]   n_bubble_cnt;

    int total;
    int bad;

    pipe_stage_skid #(
        .DATA_W        (DW),
        .SKID_EN       (1'b1),
        .ZERO_ON_FLUSH (1'b1),
        .COUNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt),
        .clr_cnt    (clr_cnt)
    );

    pipe_stage_skid #(
        .DATA_W        (DW),
        .SKID_EN       (1'b0),
        .ZERO_ON_FLUSH (1'b1),
        .COUNT_W       (16)
    ) dut_ns (
        .clk        (clk),
        .reset      (reset),
        .stall      (1'b0),
        .flush      (1'b0),
        .in_valid   (n_in_valid),
        .in_ready   (n_in_ready),
        .in_data    (n_in_data),
        .out_valid  (n_out_valid),
        .out_ready  (n_out_ready),
        .out_data   (n_out_data),
        .occupancy  (n_occupancy),
        .bubble_cnt (n_bubble_cnt),
        .clr_cnt    (1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    endtask

    task automatic test_first_transfer();
        reset = 1'b1;
        in_valid = 1'b1; in_data = DW'(8'hA5); out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL first_in_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_out_valid: got %0b want 1", out_valid); end
        total++; if (out_data !== DW'(8'hA5)) begin bad++; $display("FAIL first_out_data: got %0h want a5", out_data); end
        total++; if (bubble_cnt !== 4'd1) begin bad++; $display("FAIL first_bubble: got %0d want 1", bubble_cnt); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL first_occupancy: got %0d want 1", occupancy); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_drained: got %0b want 0", out_valid); end
        total++; if (bubble_cnt !== 4'd1) begin bad++; $display("FAIL first_bubble_hold: got %0d want 1", bubble_cnt); end
    endtask

    task automatic test_skid_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'(8'h11);
        tick();
        in_data = DW'(8'h22);
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL skid_occupancy: got %0d want 2", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_in_ready: got %0b want 0", in_ready); end
        total++; if (out_data !== DW'(8'h11)) begin bad++; $display("FAIL skid_head: got %0h want 11", out_data); end
        in_valid = 1'b0;
        stall = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_data !== DW'(8'h11)) begin bad++; $display("FAIL stall_data[%0d]: got %0h want 11", i, out_data); end
            total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL stall_occ[%0d]: got %0d want 2", i, occupancy); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %0b want 1", i, out_valid); end
        end
        stall = 1'b0;
        tick();
        total++; if (out_data !== DW'(8'h22)) begin bad++; $display("FAIL drain_second: got %0h want 22", out_data); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL drain_occ1: got %0d want 1", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready: got %0b want 1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %0b want 0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL drain_occ0: got %0d want 0", occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = DW'(8'h44);
        tick();
        in_data = DW'(8'h55);
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_prefill: got %0d want 2", occupancy); end
        flush = 1'b1; in_data = DW'(8'h33);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL flush_data: got %0h want 0", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost[%0d]: got %0b want 0 (data %0h)", i, out_valid, out_data); end
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'(8'h77);
        tick();
        in_valid = 1'b0;
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_over_stall: got %0b want 0", out_valid); end
    endtask

    task automatic test_bubble_sat();
        logic [3:0] exp;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL bubble_clr0: got %0d want 0", bubble_cnt); end
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp = (i > 15) ? 4'd15 : 4'(i);
            total++; if (bubble_cnt !== exp) begin bad++; $display("FAIL bubble_count[%0d]: got %0d want %0d", i, bubble_cnt, exp); end
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL bubble_clr: got %0d want 0", bubble_cnt); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'(8'h66);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre: got %0b want 1", out_valid); end
        #3 reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid: got %0b want 0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL areset_occ: got %0d want 0", occupancy); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL areset_data: got %0h want 0", out_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL areset_in_ready: got %0b want 0", in_ready); end
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL areset_bubble: got %0d want 0", bubble_cnt); end
        #1 reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        n_out_ready = 1'b0;
        n_in_valid = 1'b1; n_in_data = DW'(100);
        #1;
        total++; if (n_in_ready !== 1'b1) begin bad++; $display("FAIL ns_ready_empty: got %0b want 1", n_in_ready); end
        tick();
        total++; if (n_in_ready !== 1'b0) begin bad++; $display("FAIL ns_ready_blocked: got %0b want 0", n_in_ready); end
        n_in_data = DW'(99);
        tick();
        total++; if (n_occupancy !== 2'd1) begin bad++; $display("FAIL ns_no_full: got %0d want 1", n_occupancy); end
        total++; if (n_out_data !== DW'(100)) begin bad++; $display("FAIL ns_hold: got %0d want 100", n_out_data); end
        n_out_ready = 1'b1;
        #1;
        total++; if (n_in_ready !== 1'b1) begin bad++; $display("FAIL ns_ready_comb: got %0b want 1", n_in_ready); end
        for (int k = 1; k <= 4; k++) begin
            n_in_data = DW'(100 + k);
            tick();
            total++; if (n_out_data !== DW'(100 + k)) begin bad++; $display("FAIL ns_b2b_data[%0d]: got %0d want %0d", k, n_out_data, 100 + k); end
            total++; if (n_out_valid !== 1'b1 || n_occupancy !== 2'd1) begin bad++; $display("FAIL ns_b2b_state[%0d]: got valid=%0b occ=%0d want valid=1 occ=1", k, n_out_valid, n_occupancy); end
        end
        n_in_valid = 1'b0;
        tick();
        total++; if (n_out_valid !== 1'b0) begin bad++; $display("FAIL ns_drain: got %0b want 0", n_out_valid); end
    endtask

    initial begin
        total = 0; bad = 0;
        stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        test_reset();
        test_first_transfer();
        test_skid_stall();
        test_flush();
        test_bubble_sat();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
